// File: rtl/fft_ctrl_param.sv
// fft_ctrl_param: control sequencer for a radix-2 N-point FFT (N = 2**LOG2N).
// A frame runs as: N load cycles, then LOG2N stage windows of STAGE_CYC cycles
// each, then a one-cycle done pulse.
// Parameters: LOG2N (1..10), STAGE_CYC (1..15).
// Ports:
//   clk, reset_n   rising-edge clock, asynchronous active-low reset
//   start, abort   frame request; synchronous abort (abort wins over start)
//   en_s2p         s2p load enable, high for N cycles per frame
//   s2p_idx        sample index during load
//   en_stage       one-hot stage enable
//   stage_idx      binary index of the active stage
//   busy, done     busy from first LOAD cycle through DONE; done pulse
// Optional macro FFT_CTRL_PENDING_START_EN: queues one start seen while busy
// and chains straight from DONE into the next LOAD.
module fft_ctrl_param #(
   parameter int unsigned LOG2N     = 3,
   parameter int unsigned STAGE_CYC = 1
) (
   input  logic                                          clk,
   input  logic                                          reset_n,
   input  logic                                          start,
   input  logic                                          abort,
   output logic                                          en_s2p,
   output logic [LOG2N-1:0]                              s2p_idx,
   output logic [LOG2N-1:0]                              en_stage,
   output logic [((LOG2N > 1) ? $clog2(LOG2N) : 1)-1:0]  stage_idx,
   output logic                                          busy,
   output logic                                          done
);

   localparam int unsigned LW = LOG2N;
   localparam int unsigned SW = (LOG2N > 1) ? $clog2(LOG2N) : 1;
   localparam int unsigned CW = 4;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_STAGE = 2'd2,
      S_DONE  = 2'd3
   } state_e;

   state_e          state_q, state_d;
   logic [LW-1:0]   load_cnt_q, load_cnt_d;
   logic [SW-1:0]   stage_cnt_q, stage_cnt_d;
   logic [CW-1:0]   cyc_cnt_q, cyc_cnt_d;
`ifdef FFT_CTRL_PENDING_START_EN
   logic            pend_q, pend_d;
`endif

   logic            en_s2p_d;
   logic [LW-1:0]   s2p_idx_d;
   logic [LW-1:0]   en_stage_d;
   logic [SW-1:0]   stage_idx_d;
   logic            busy_d;
   logic            done_d;

   // Next-state and counter update
   always_comb begin
      state_d     = state_q;
      load_cnt_d  = load_cnt_q;
      stage_cnt_d = stage_cnt_q;
      cyc_cnt_d   = cyc_cnt_q;
`ifdef FFT_CTRL_PENDING_START_EN
      pend_d      = pend_q;
`endif
      if (abort) begin
         state_d     = S_IDLE;
         load_cnt_d  = '0;
         stage_cnt_d = '0;
         cyc_cnt_d   = '0;
`ifdef FFT_CTRL_PENDING_START_EN
         pend_d      = 1'b0;
`endif
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_d    = S_LOAD;
                  load_cnt_d = '0;
               end
            end
            S_LOAD: begin
`ifdef FFT_CTRL_PENDING_START_EN
               if (start) pend_d = 1'b1;
`endif
               // Counter wraps naturally to 0 on the last sample.
               load_cnt_d = load_cnt_q + LW'(1);
               if (&load_cnt_q) begin
                  state_d     = S_STAGE;
                  stage_cnt_d = '0;
                  cyc_cnt_d   = '0;
               end
            end
            S_STAGE: begin
`ifdef FFT_CTRL_PENDING_START_EN
               if (start) pend_d = 1'b1;
`endif
               if (cyc_cnt_q == CW'(STAGE_CYC - 1)) begin
                  cyc_cnt_d = '0;
                  if (stage_cnt_q == SW'(LOG2N - 1)) state_d = S_DONE;
                  else stage_cnt_d = stage_cnt_q + SW'(1);
               end else begin
                  cyc_cnt_d = cyc_cnt_q + CW'(1);
               end
            end
            S_DONE: begin
               state_d = S_IDLE;
`ifdef FFT_CTRL_PENDING_START_EN
               if (pend_q || start) begin
                  state_d    = S_LOAD;
                  load_cnt_d = '0;
                  pend_d     = 1'b0;
               end
`endif
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Moore output decode of the next state, registered below
   always_comb begin
      en_s2p_d    = 1'b0;
      s2p_idx_d   = '0;
      en_stage_d  = '0;
      stage_idx_d = '0;
      busy_d      = (state_d != S_IDLE);
      done_d      = (state_d == S_DONE);
      if (state_d == S_LOAD) begin
         en_s2p_d  = 1'b1;
         s2p_idx_d = load_cnt_d;
      end
      if (state_d == S_STAGE) begin
         en_stage_d  = LW'(1) << stage_cnt_d;
         stage_idx_d = stage_cnt_d;
      end
   end

   // State, counter and output registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         load_cnt_q  <= '0;
         stage_cnt_q <= '0;
         cyc_cnt_q   <= '0;
`ifdef FFT_CTRL_PENDING_START_EN
         pend_q      <= 1'b0;
`endif
         en_s2p      <= 1'b0;
         s2p_idx     <= '0;
         en_stage    <= '0;
         stage_idx   <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         state_q     <= state_d;
         load_cnt_q  <= load_cnt_d;
         stage_cnt_q <= stage_cnt_d;
         cyc_cnt_q   <= cyc_cnt_d;
`ifdef FFT_CTRL_PENDING_START_EN
         pend_q      <= pend_d;
`endif
         en_s2p      <= en_s2p_d;
         s2p_idx     <= s2p_idx_d;
         en_stage    <= en_stage_d;
         stage_idx   <= stage_idx_d;
         busy        <= busy_d;
         done        <= done_d;
      end
   end

endmodule

// File: tb/tb_fft_ctrl_param.sv
// Testbench for fft_ctrl_param: two instances (LOG2N=3/STAGE_CYC=1 and
// LOG2N=4/STAGE_CYC=3) share stimulus; a frame-schedule model predicts every
// output each cycle, and directed literal checks pin the key timing points.
module tb_fft_ctrl_param;

   logic clk;
   logic reset_n;
   logic start;
   logic abort;

   logic       d3_en_s2p, d3_busy, d3_done;
   logic [2:0] d3_idx, d3_stg;
   logic [1:0] d3_sidx;
   logic       d4_en_s2p, d4_busy, d4_done;
   logic [3:0] d4_idx, d4_stg;
   logic [1:0] d4_sidx;

   int n_vec = 0;
   int n_err = 0;

   fft_ctrl_param #(.LOG2N(3), .STAGE_CYC(1)) dut3 (
      .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
      .en_s2p(d3_en_s2p), .s2p_idx(d3_idx), .en_stage(d3_stg),
      .stage_idx(d3_sidx), .busy(d3_busy), .done(d3_done)
   );

   fft_ctrl_param #(.LOG2N(4), .STAGE_CYC(3)) dut4 (
      .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
      .en_s2p(d4_en_s2p), .s2p_idx(d4_idx), .en_stage(d4_stg),
      .stage_idx(d4_sidx), .busy(d4_busy), .done(d4_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: a frame is "active" with t = cycles since its first LOAD cycle.
   typedef struct {
      bit active;
      int t;
      bit pend;
   } mdl_t;

   mdl_t m3 = '{1'b0, 0, 1'b0};
   mdl_t m4 = '{1'b0, 0, 1'b0};

   function automatic mdl_t mstep(input mdl_t m, input int n, input int l,
                                  input int s, input bit st, input bit ab);
      mdl_t r;
      int   last;
      r    = m;
      last = n + l * s;
      if (ab) begin
         r.active = 1'b0; r.t = 0; r.pend = 1'b0;
      end else if (!m.active) begin
         if (st) begin r.active = 1'b1; r.t = 0; end
      end else if (m.t == last) begin
`ifdef FFT_CTRL_PENDING_START_EN
         if (m.pend || st) begin r.t = 0; r.pend = 1'b0; end
         else r.active = 1'b0;
`else
         r.active = 1'b0;
`endif
      end else begin
`ifdef FFT_CTRL_PENDING_START_EN
         if (st) r.pend = 1'b1;
`endif
         r.t = m.t + 1;
      end
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      n_vec++;
      if (act !== want) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, want, $time);
      end
   endtask

   task automatic cmp_dut(input string nm, input mdl_t m, input int n, input int l,
                          input int s, input logic [31:0] a_en, input logic [31:0] a_idx,
                          input logic [31:0] a_stg, input logic [31:0] a_sidx,
                          input logic [31:0] a_busy, input logic [31:0] a_done);
      int e_en, e_idx, e_stg, e_sidx;
      e_en   = (m.active && m.t < n) ? 1 : 0;
      e_idx  = (e_en == 1) ? m.t : 0;
      e_stg  = 0;
      e_sidx = 0;
      if (m.active && m.t >= n && m.t < n + l * s) begin
         e_sidx = (m.t - n) / s;
         e_stg  = 1 << e_sidx;
      end
      chk({nm, ".en_s2p"},    a_en,   32'(e_en));
      chk({nm, ".s2p_idx"},   a_idx,  32'(e_idx));
      chk({nm, ".en_stage"},  a_stg,  32'(e_stg));
      chk({nm, ".stage_idx"}, a_sidx, 32'(e_sidx));
      chk({nm, ".busy"},      a_busy, (m.active) ? 32'd1 : 32'd0);
      chk({nm, ".done"},      a_done, (m.active && m.t == n + l * s) ? 32'd1 : 32'd0);
   endtask

   // Model advance mirrors the sampling edge; reset clears it immediately
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m3 = '{1'b0, 0, 1'b0};
         m4 = '{1'b0, 0, 1'b0};
      end else begin
         m3 = mstep(m3, 8, 3, 1, start, abort);
         m4 = mstep(m4, 16, 4, 3, start, abort);
      end
   end

   // Single compare process, every cycle, away from the active edge
   always @(negedge clk) begin
      cmp_dut("m3", m3, 8, 3, 1, 32'(d3_en_s2p), 32'(d3_idx), 32'(d3_stg),
              32'(d3_sidx), 32'(d3_busy), 32'(d3_done));
      cmp_dut("m4", m4, 16, 4, 3, 32'(d4_en_s2p), 32'(d4_idx), 32'(d4_stg),
              32'(d4_sidx), 32'(d4_busy), 32'(d4_done));
   end

   task automatic all_zero3(input string nm);
      chk({nm, ".en_s2p"},   32'(d3_en_s2p), 32'd0);
      chk({nm, ".en_stage"}, 32'(d3_stg),    32'd0);
      chk({nm, ".busy"},     32'(d3_busy),   32'd0);
      chk({nm, ".done"},     32'(d3_done),   32'd0);
   endtask

   initial begin
      reset_n = 1'b0;
      start   = 1'b0;
      abort   = 1'b0;
      repeat (2) @(negedge clk);
      all_zero3("rst");
      chk("rst.s2p_idx", 32'(d3_idx), 32'd0);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);

      // Frame on N=8, STAGE_CYC=1: start held during cycle 0 only
      start = 1'b1;
      for (int c = 1; c <= 14; c++) begin
         @(negedge clk);
         start = 1'b0;
         chk("t1.en_s2p",   32'(d3_en_s2p), (c >= 1 && c <= 8) ? 32'd1 : 32'd0);
         chk("t1.s2p_idx",  32'(d3_idx),    (c <= 8) ? 32'(c - 1) : 32'd0);
         chk("t1.en_stage", 32'(d3_stg),    (c == 9) ? 32'd1 : (c == 10) ? 32'd2 :
                                            (c == 11) ? 32'd4 : 32'd0);
         chk("t1.done",     32'(d3_done),   (c == 12) ? 32'd1 : 32'd0);
         chk("t1.busy",     32'(d3_busy),   (c <= 12) ? 32'd1 : 32'd0);
      end
      repeat (40) @(negedge clk);

      // Frame on N=16, STAGE_CYC=3
      start = 1'b1;
      for (int c = 1; c <= 31; c++) begin
         @(negedge clk);
         start = 1'b0;
         chk("t2.en_s2p",  32'(d4_en_s2p), (c <= 16) ? 32'd1 : 32'd0);
         chk("t2.s2p_idx", 32'(d4_idx),    (c <= 16) ? 32'(c - 1) : 32'd0);
         if (c >= 17 && c <= 28) begin
            chk("t2.en_stage",  32'(d4_stg),  32'(1 << ((c - 17) / 3)));
            chk("t2.stage_idx", 32'(d4_sidx), 32'((c - 17) / 3));
         end else begin
            chk("t2.en_stage",  32'(d4_stg),  32'd0);
         end
         chk("t2.done", 32'(d4_done), (c == 29) ? 32'd1 : 32'd0);
         chk("t2.busy", 32'(d4_busy), (c <= 29) ? 32'd1 : 32'd0);
      end
      repeat (40) @(negedge clk);

      // Abort during stage 1 (cycle 10), fresh start in cycle 15
      start = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (c >= 11 && c <= 15) all_zero3("t3.abort");
         if (c == 16) begin
            chk("t3.restart_en",  32'(d3_en_s2p), 32'd1);
            chk("t3.restart_idx", 32'(d3_idx),    32'd0);
         end
         start = (c == 15);
         abort = (c == 10);
      end
      start = 1'b0;
      abort = 1'b0;
      repeat (50) @(negedge clk);

      // Start pulsed during LOAD (cycle 5)
      start = 1'b1;
      for (int c = 1; c <= 26; c++) begin
         @(negedge clk);
         if (c == 12) chk("t4.done1", 32'(d3_done), 32'd1);
`ifdef FFT_CTRL_PENDING_START_EN
         chk("t4.busy", 32'(d3_busy), (c <= 24) ? 32'd1 : 32'd0);
         if (c == 13) begin
            chk("t4.reload_en",  32'(d3_en_s2p), 32'd1);
            chk("t4.reload_idx", 32'(d3_idx),    32'd0);
         end
         if (c == 24) chk("t4.done2", 32'(d3_done), 32'd1);
`else
         chk("t4.busy", 32'(d3_busy), (c <= 12) ? 32'd1 : 32'd0);
         if (c > 12) chk("t4.no_done", 32'(d3_done), 32'd0);
`endif
         start = (c == 5);
      end
      start = 1'b0;
      repeat (70) @(negedge clk);

      // Start held high continuously: back-to-back frames
      start = 1'b1;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         if (c == 12) chk("t5.done1", 32'(d3_done), 32'd1);
`ifdef FFT_CTRL_PENDING_START_EN
         if (c == 13) chk("t5.chain_en", 32'(d3_en_s2p), 32'd1);
         if (c == 24) chk("t5.done2",    32'(d3_done),   32'd1);
`else
         if (c == 13) chk("t5.gap_busy", 32'(d3_busy),   32'd0);
         if (c == 14) chk("t5.next_en",  32'(d3_en_s2p), 32'd1);
         if (c == 14) chk("t5.next_idx", 32'(d3_idx),    32'd0);
         if (c == 25) chk("t5.done2",    32'(d3_done),   32'd1);
`endif
      end
      start = 1'b0;
      repeat (70) @(negedge clk);

      // Abort together with start in IDLE, then abort alone in IDLE
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      chk("t6.abort_wins3", 32'(d3_busy), 32'd0);
      chk("t6.abort_wins4", 32'(d4_busy), 32'd0);
      start = 1'b0;
      @(negedge clk);
      all_zero3("t6.idle_abort");
      abort = 1'b0;
      repeat (3) @(negedge clk);

      // Asynchronous reset between edges during LOAD (cycle 4)
      start = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         start = 1'b0;
      end
      chk("t7.pre_en",  32'(d3_en_s2p), 32'd1);
      chk("t7.pre_idx", 32'(d3_idx),    32'd3);
      #1 reset_n = 1'b0;
      #1;
      all_zero3("t7.async3");
      chk("t7.async_idx", 32'(d3_idx),    32'd0);
      chk("t7.async4",    32'(d4_en_s2p), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         all_zero3("t7.stay_idle");
      end
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("t7.fresh_en",  32'(d3_en_s2p), 32'd1);
      chk("t7.fresh_idx", 32'(d3_idx),    32'd0);
      repeat (40) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/fft_ctrl_param.md
Name: fft_ctrl_param

Overview:
Parametrised control sequencer for a radix-2 N-point FFT datapath, with N = 2^LOG2N. It is the generalised successor of the fixed 8-point FFT control FSM.
- Sequences the serial-to-parallel load phase, then one enable window per butterfly stage, then a done pulse.
- Adds multi-cycle stage windows, a busy/done handshake, synchronous abort, and optional queuing of a start request.
- Sits between the system front-end (start/abort) and the s2p buffer plus butterfly stage banks.

Parameters:
- LOG2N, 3, log2 of FFT points; N = 2^LOG2N. Legal range 1..10.
- STAGE_CYC, 1, cycles each stage enable is held (butterfly pipeline depth). Legal range 1..15.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  frame request, sampled each rising edge
- abort  in  1  synchronous abort; overrides start
- en_s2p  out  1  s2p load enable, high for N cycles per frame
- s2p_idx  out  LOG2N  sample index during load, 0..N-1
- en_stage  out  LOG2N  one-hot stage enable; bit s drives every butterfly of stage s
- stage_idx  out  max(1,$clog2(LOG2N))  binary index of the active stage
- busy  out  1  high from the first LOAD cycle through the DONE cycle
- done  out  1  one-cycle pulse at frame completion

Behaviour:
- Reset (reset_n=0, asynchronous): state=IDLE; en_s2p=0, s2p_idx=0, en_stage=0, stage_idx=0, busy=0, done=0; pending flag cleared.
- All outputs are registered and are a Moore decode of the state registers. There are no combinational paths from inputs to outputs.
- States: IDLE, LOAD, STAGE, DONE. Counters: load_cnt (LOG2N bits), stage_cnt, cyc_cnt (4 bits).
- IDLE: start=1 at edge k moves to LOAD in cycle k+1, with load_cnt=0.
- LOAD: en_s2p=1 and s2p_idx=load_cnt.
  - load_cnt increments each cycle.
  - At load_cnt=N-1, move to STAGE with stage_cnt=0 and cyc_cnt=0.
  - load_cnt wraps to 0 without any glitch on en_s2p.
- STAGE: en_stage = 1<<stage_cnt and stage_idx=stage_cnt.
  - Each stage is held for STAGE_CYC cycles.
  - After the last cycle of stage LOG2N-1, move to DONE.
- DONE: done=1 and busy=1 for exactly one cycle, then return to IDLE. If a start is pending (optional feature), go directly to LOAD instead.
- Frame latency: start at edge k gives en_s2p in cycles k+1..k+N and done in cycle k+N+LOG2N*STAGE_CYC+1. Busy lasts N+LOG2N*STAGE_CYC+1 cycles.
- start while busy with the macro undefined: ignored.
- start held high continuously: frames run back-to-back, with one IDLE cycle between DONE and the next LOAD.
- abort=1 in any state: next cycle is IDLE, all outputs are at reset values, no done pulse, and pending is cleared. If abort and start are asserted in the same cycle, abort wins.
- abort in IDLE: no effect.
- Reset asserted mid-frame: outputs clear immediately (asynchronous). Operation resumes only on a fresh start after reset_n deasserts.
- Only one bit of en_stage is ever high. en_s2p and en_stage are never simultaneously active.

Optional Feature:
- Macro: FFT_CTRL_PENDING_START_EN.
- Defined:
  - start seen while busy (and not in DONE) sets a pending flag.
  - In DONE, a pending flag or start=1 moves the block directly to LOAD, with no IDLE gap. busy stays high and pending clears.
  - A second start while pending is already set is dropped (queue depth 1).
- Undefined: there is no pending flag; start is honoured only in IDLE.

Test Plan:
- LOG2N=3, STAGE_CYC=1, one-cycle start at edge 0:
  - en_s2p high cycles 1..8, with s2p_idx 0..7.
  - en_stage = 001/010/100 in cycles 9/10/11.
  - done=1 in cycle 12 only; busy high in cycles 1..12.
- LOG2N=4, STAGE_CYC=3:
  - en_s2p high for 16 cycles.
  - Each of the 4 stage bits is high for 3 cycles, with stage_idx 0..3.
  - done occurs 29 cycles after start.
- abort asserted in cycle 10 of the first test (during stage 1): all outputs 0 from cycle 11, no done, busy=0. A start in cycle 15 begins a clean frame at s2p_idx=0.
- start pulsed in cycle 5 (during LOAD):
  - Macro undefined: no second frame.
  - Macro defined: LOAD restarts in cycle 13 immediately after done, busy stays continuously high, and a second done appears in cycle 24.
- reset_n dropped asynchronously mid-LOAD (cycle 4, between edges): all outputs 0 before the next edge. After release, the block stays IDLE until start.
